// File: rtl/cachelinebus_pkg.sv
// Shared types and default geometry for the cache line-transfer bus responder.
// The geometry constants are the defaults the cache instance is built with.
package cachelinebus_pkg;

  localparam int PA_BITS_DEF = 32;
  localparam int LINELEN_DEF = 256;
  localparam int BEATLEN_DEF = 64;
  localparam int LOGBWPL_DEF = $clog2(LINELEN_DEF / BEATLEN_DEF);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    F_REQ   = 3'd1,
    F_WAIT  = 3'd2,
    WB_READ = 3'd3,
    WB_SEND = 3'd4,
    ACK     = 3'd5
  } busState_t;

  // Byte-address shift between consecutive beats of a line.
  function automatic int beatByteShift(input int beatLen);
    return $clog2(beatLen / 8);
  endfunction

endpackage

// File: rtl/cachelinebus_if.sv
// Memory-side beat port: one request at a time, accepted on MemReq & MemReady,
// read data returned later on MemRValid.
interface cachelinebus_if #(
  parameter int PA_BITS = 32,
  parameter int BEATLEN = 64
);

  logic               MemReq;
  logic               MemWrite;
  logic [PA_BITS-1:0] MemAdr;
  logic [BEATLEN-1:0] MemWData;
  logic               MemReady;
  logic               MemRValid;
  logic [BEATLEN-1:0] MemRData;

  modport master (
    output MemReq, MemWrite, MemAdr, MemWData,
    input  MemReady, MemRValid, MemRData
  );

  modport slave (
    input  MemReq, MemWrite, MemAdr, MemWData,
    output MemReady, MemRValid, MemRData
  );

endinterface

// File: rtl/cachelinebus_fetchbuf.sv
// Line-wide fetch buffer written one beat at a time at the beat index.
// Untouched beats keep their value; async reset clears the whole line.
module cachelinebus_fetchbuf #(
  parameter int LINELEN = 256,
  parameter int BEATLEN = 64,
  parameter int LOGBWPL = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [LOGBWPL-1:0] beatIdx,
  input  logic [BEATLEN-1:0] wData,
  output logic [LINELEN-1:0] line
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line <= '0;
    end else if (we) begin
      line[int'(beatIdx) * BEATLEN +: BEATLEN] <= wData;
    end
  end

endmodule

// File: rtl/cachelinebus.sv
// Serializes a cache line fetch or writeback into single-outstanding memory beats,
// assembling fetched beats into FetchBuffer and pulsing CacheBusAck when done.
module cachelinebus
  import cachelinebus_pkg::*;
#(
  parameter int PA_BITS = PA_BITS_DEF,
  parameter int LINELEN = LINELEN_DEF,
  parameter int BEATLEN = BEATLEN_DEF,
  parameter int LOGBWPL = LOGBWPL_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         CacheBusRW,
  input  logic [PA_BITS-1:0] CacheBusAdr,
  input  logic [BEATLEN-1:0] CacheReadDataWord,
  output logic               CacheBusAck,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic               SelBusBeat,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic               BusCommitted,
  cachelinebus_if.master     memBus
);

  localparam int ADR_SHIFT = beatByteShift(BEATLEN);

  busState_t          state;
  busState_t          nextState;
  logic               lastBeat;
  logic               startBurst;
  logic               beatAdvance;
  logic               fetchWe;
  logic [BEATLEN-1:0] wDataReg;

  assign lastBeat   = (BeatCount == {LOGBWPL{1'b1}});
  assign startBurst = (state == IDLE) && (CacheBusRW != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Writeback wins over fetch when the cache (illegally) asserts both.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (CacheBusRW[0])      nextState = WB_READ;
        else if (CacheBusRW[1]) nextState = F_REQ;
      end
      F_REQ: begin
        if (memBus.MemReady) nextState = F_WAIT;
      end
      F_WAIT: begin
        if (memBus.MemRValid) nextState = lastBeat ? ACK : F_REQ;
      end
      WB_READ: nextState = WB_SEND;
      WB_SEND: begin
        if (memBus.MemReady) nextState = lastBeat ? ACK : WB_READ;
      end
      ACK:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    memBus.MemReq   = 1'b0;
    memBus.MemWrite = 1'b0;
    CacheBusAck     = 1'b0;
    SelBusBeat      = 1'b0;
    BusCommitted    = (state != IDLE) && (state != ACK);
    fetchWe         = 1'b0;
    beatAdvance     = 1'b0;
    case (state)
      F_REQ: begin
        memBus.MemReq = 1'b1;
      end
      F_WAIT: begin
        fetchWe     = memBus.MemRValid;
        beatAdvance = memBus.MemRValid && !lastBeat;
      end
      WB_READ: begin
        SelBusBeat = 1'b1;
      end
      WB_SEND: begin
        memBus.MemReq   = 1'b1;
        memBus.MemWrite = 1'b1;
        SelBusBeat      = 1'b1;
        beatAdvance     = memBus.MemReady && !lastBeat;
      end
      ACK: begin
        CacheBusAck = 1'b1;
      end
      default: begin
        CacheBusAck = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BeatCount <= '0;
    end else if (startBurst) begin
      BeatCount <= '0;
    end else if (beatAdvance) begin
      BeatCount <= BeatCount + 1'b1;
    end
  end

  // Captured during the cache read cycle so write data is stable for the whole send.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wDataReg <= '0;
    end else if (state == WB_READ) begin
      wDataReg <= CacheReadDataWord;
    end
  end

  assign memBus.MemWData = wDataReg;
  assign memBus.MemAdr   = CacheBusAdr + (PA_BITS'(BeatCount) << ADR_SHIFT);

  cachelinebus_fetchbuf #(
    .LINELEN (LINELEN),
    .BEATLEN (BEATLEN),
    .LOGBWPL (LOGBWPL)
  ) fetchBuf (
    .clk     (clk),
    .reset   (reset),
    .we      (fetchWe),
    .beatIdx (BeatCount),
    .wData   (memBus.MemRData),
    .line    (FetchBuffer)
  );

endmodule

// File: tb/tb_cachelinebus.sv
// Directed bench for cachelinebus: a beat/flag-level line-transfer model checked every
// cycle, plus literal expectations for latency, addresses, write data and reset abort.
module tb_cachelinebus;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   CacheBusRW = 2'b00;
  logic [31:0]  CacheBusAdr = 32'h0;
  logic [63:0]  CacheReadDataWord;
  logic         CacheBusAck;
  logic [1:0]   BeatCount;
  logic         SelBusBeat;
  logic [255:0] FetchBuffer;
  logic         BusCommitted;

  cachelinebus_if #(.PA_BITS(32), .BEATLEN(64)) memBus ();

  cachelinebus dut (
    .clk               (clk),
    .reset             (reset),
    .CacheBusRW        (CacheBusRW),
    .CacheBusAdr       (CacheBusAdr),
    .CacheReadDataWord (CacheReadDataWord),
    .CacheBusAck       (CacheBusAck),
    .BeatCount         (BeatCount),
    .SelBusBeat        (SelBusBeat),
    .FetchBuffer       (FetchBuffer),
    .BusCommitted      (BusCommitted),
    .memBus            (memBus)
  );

  always #5 clk = ~clk;

  // Cache side: the word for beat k is 0xA0+k.
  assign CacheReadDataWord = 64'hA0 + 64'(BeatCount);

  int nVec = 0;
  int nBad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Line-transfer model: 0 idle, 1 transferring, 2 acknowledging.
  int          mState = 0;
  int          mBeats = 0;
  bit          mWb = 1'b0;
  bit          mOut = 1'b0;
  bit          mPrimed = 1'b0;
  logic [31:0] mBase = 32'h0;
  logic [63:0] mLine [4] = '{default: 64'h0};

  function automatic logic [255:0] modelLine();
    return {mLine[3], mLine[2], mLine[1], mLine[0]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState = 0; mBeats = 0; mOut = 0; mPrimed = 0;
      for (int i = 0; i < 4; i++) mLine[i] = 64'h0;
    end else begin
      case (mState)
        0: if (CacheBusRW != 2'b00) begin
          mWb = CacheBusRW[0]; mBase = CacheBusAdr;
          mState = 1; mBeats = 0; mOut = 0; mPrimed = 0;
        end
        1: if (mWb) begin
          // each write beat needs one cache-read cycle before it can be offered
          if (!mPrimed) mPrimed = 1;
          else if (memBus.MemReady) begin
            mBeats++; mPrimed = 0;
            if (mBeats == 4) mState = 2;
          end
        end else begin
          if (!mOut) begin
            if (memBus.MemReady) mOut = 1;
          end else if (memBus.MemRValid) begin
            mLine[mBeats] = memBus.MemRData; mBeats++; mOut = 0;
            if (mBeats == 4) mState = 2;
          end
        end
        default: mState = 0;
      endcase
    end
  end

  logic [31:0] adrQ[$];
  logic [63:0] wrQ[$];
  int          rdCnt = 0;
  int          ackCnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      bit er;
      er = (mState == 1) && (mWb ? mPrimed : !mOut);
      chk("ack", CacheBusAck, mState == 2);
      chk("committed", BusCommitted, mState == 1);
      chk("selbeat", SelBusBeat, (mState == 1) && mWb);
      chk("memreq", memBus.MemReq, er);
      chk("memwrite", memBus.MemWrite, er && mWb);
      if (er) begin
        chk("memadr", memBus.MemAdr, mBase + 32'(mBeats * 8));
        chk("beatcount", BeatCount, mBeats);
        if (mWb) chk("memwdata", memBus.MemWData, 64'hA0 + 64'(mBeats));
      end
      chk("fetchbuf", FetchBuffer, modelLine());
      if (CacheBusAck) ackCnt++;
      if (memBus.MemReq && memBus.MemReady) begin
        adrQ.push_back(memBus.MemAdr);
        if (memBus.MemWrite) wrQ.push_back(memBus.MemWData);
        else rdCnt++;
      end
    end
  end

  // Memory responder: read data arrives rdDelay cycles after the accepting cycle.
  int          rdDelay = 1;
  int          pendCnt = 0;
  bit          pendAct = 1'b0;
  logic [31:0] pendAdr = 32'h0;
  logic [31:0] stallAdr = 32'h0;
  int          stallLeft = 0;

  initial begin
    memBus.MemRValid = 1'b0;
    memBus.MemRData  = 64'h0;
    forever begin
      @(negedge clk);
      if (!reset && memBus.MemReq && memBus.MemReady && !memBus.MemWrite) begin
        pendAct = 1; pendCnt = rdDelay; pendAdr = memBus.MemAdr;
      end
      @(posedge clk); #1;
      memBus.MemRValid = 1'b0;
      if (reset) pendAct = 0;
      else if (pendAct) begin
        pendCnt--;
        if (pendCnt == 0) begin
          memBus.MemRValid = 1'b1;
          memBus.MemRData  = 64'((pendAdr - CacheBusAdr) >> 3) + 64'h11;
          pendAct = 0;
        end
      end
    end
  end

  initial begin
    memBus.MemReady = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (stallLeft > 0 && memBus.MemReq && memBus.MemAdr == stallAdr) begin
        memBus.MemReady = 1'b0; stallLeft--;
      end else begin
        memBus.MemReady = 1'b1;
      end
    end
  end

  task automatic clearLogs();
    adrQ.delete(); wrQ.delete(); rdCnt = 0; ackCnt = 0;
  endtask

  // Cycle 0 is the IDLE cycle in which the request is first presented.
  task automatic runBurst(input logic [1:0] rw, input logic [31:0] adr,
                          input int budget, output int ackCyc);
    int c; bit got;
    c = 0; got = 0; ackCyc = -1;
    @(posedge clk); #1;
    CacheBusRW = rw; CacheBusAdr = adr;
    while (!got && c <= budget) begin
      @(negedge clk);
      if (CacheBusAck) got = 1;
      else c++;
    end
    if (got) ackCyc = c;
    else begin
      nVec++; nBad++;
      $display("FAIL ack_timeout: no ack within %0d cycles for adr %0h", budget, adr);
    end
  endtask

  task automatic endBurst();
    @(posedge clk); #1;
    CacheBusRW = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [255:0] expLine;

  initial begin
    int cyc, c1, c2, n;
    bit seen;
    expLine = {64'h14, 64'h13, 64'h12, 64'h11};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memreq", memBus.MemReq, 0);
    chk("rst_fetchbuf", FetchBuffer, 0);
    chk("rst_beatcount", BeatCount, 0);
    chk("rst_wdata", memBus.MemWData, 0);
    chk("rst_ack", CacheBusAck, 0);
    chk("rst_committed", BusCommitted, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fetch, zero-wait memory
    clearLogs(); rdDelay = 1;
    runBurst(2'b10, 32'h8000_0040, 40, cyc); endBurst(); idle(1);
    chk("t1_ack_cycle", cyc, 9);
    chk("t1_nbeats", adrQ.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < adrQ.size()) chk("t1_adr", adrQ[i], 32'h8000_0040 + 32'(8 * i));
    chk("t1_line", FetchBuffer, expLine);

    // Writeback with MemReady low for 3 cycles on beat 1
    clearLogs(); stallAdr = 32'h1008; stallLeft = 3;
    runBurst(2'b01, 32'h1000, 60, cyc); endBurst(); idle(3);
    chk("t2_ack_cycle", cyc, 12);
    chk("t2_nwrites", wrQ.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wrQ.size()) chk("t2_wdata", wrQ[i], 64'hA0 + 64'(i));
    chk("t2_acks", ackCnt, 1);
    chk("t2_line_kept", FetchBuffer, expLine);

    // Writeback immediately followed by fetch
    clearLogs();
    runBurst(2'b01, 32'h2000, 40, c1);
    runBurst(2'b10, 32'h3000, 40, c2); endBurst(); idle(2);
    chk("t3_acks", ackCnt, 2);
    chk("t3_wb_cycle", c1, 9);
    chk("t3_fetch_cycle", c2, 9);
    chk("t3_writes", wrQ.size(), 4);
    chk("t3_reads", rdCnt, 4);
    if (adrQ.size() > 4) chk("t3_fetch_first_adr", adrQ[4], 32'h3000);

    // Reset while waiting for beat 2 data
    clearLogs(); rdDelay = 3;
    @(posedge clk); #1;
    CacheBusRW = 2'b10; CacheBusAdr = 32'h4000;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk); #1;
      if (adrQ.size() >= 3) seen = 1;
      n++;
    end
    chk("t4_reached_beat2", seen, 1);
    chk("t4_partial_line", FetchBuffer[127:0], {64'h12, 64'h11});
    @(posedge clk); #1;
    reset = 1'b1; pendAct = 0; CacheBusRW = 2'b00;
    @(negedge clk);
    chk("t4_fetchbuf", FetchBuffer, 0);
    chk("t4_memreq", memBus.MemReq, 0);
    chk("t4_ack", CacheBusAck, 0);
    chk("t4_committed", BusCommitted, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(5);
    chk("t4_no_ack", ackCnt, 0);

    // Illegal RW=11 performs a writeback
    clearLogs(); rdDelay = 1;
    runBurst(2'b11, 32'h5000, 40, cyc); endBurst(); idle(1);
    chk("t5_ack_cycle", cyc, 9);
    chk("t5_writes", wrQ.size(), 4);
    chk("t5_reads", rdCnt, 0);

    // Read data 5 cycles after accept
    clearLogs(); rdDelay = 5;
    runBurst(2'b10, 32'h6000, 80, cyc); endBurst(); idle(1);
    chk("t6_ack_cycle", cyc, 25);
    chk("t6_reads", rdCnt, 4);
    chk("t6_line", FetchBuffer, expLine);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cachelinebus.md
Name: cachelinebus

Overview:
- Bus-side responder for the cache line-transfer interface (CacheBusRW/CacheBusAdr/CacheBusAck/BeatCount/SelBusBeat/FetchBuffer).
- Accepts a line fetch or line writeback from an I$ or D$ and serializes it into single-outstanding beat transactions on a simple memory-side request/ready/rvalid port.
- Assembles fetched beats into FetchBuffer and returns a one-cycle CacheBusAck on completion.
- Sits between the cache and the AHB/memory adapter.

Parameters:
- PA_BITS, 32, physical address width
- LINELEN, 256, cache line bits
- BEATLEN, 64, bits per bus beat; LINELEN/BEATLEN must be a power of 2 and at least 2
- LOGBWPL, 2, log2(LINELEN/BEATLEN); must match the cache instance

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- CacheBusRW  in  2  [1] line fetch, [0] line writeback; held by cache until CacheBusAck
- CacheBusAdr  in  PA_BITS  line-aligned address
- CacheReadDataWord  in  BEATLEN  cache word selected by BeatCount, valid one cycle after BeatCount changes
- CacheBusAck  out  1  transfer complete, one-cycle pulse
- BeatCount  out  LOGBWPL  current beat index
- SelBusBeat  out  1  high in writeback states; cache indexes its word by BeatCount
- FetchBuffer  out  LINELEN  assembled fetched line
- BusCommitted  out  1  burst in progress (state != IDLE and state != ACK)
- MemReq  out  1  beat request valid
- MemWrite  out  1  1 = write beat
- MemAdr  out  PA_BITS  CacheBusAdr + BeatCount*(BEATLEN/8)
- MemWData  out  BEATLEN  write data, registered
- MemReady  in  1  beat accepted when MemReq & MemReady
- MemRValid  in  1  read data valid
- MemRData  in  BEATLEN  read data

Behaviour:
- Reset values: state IDLE; BeatCount 0; FetchBuffer 0; MemWData 0; all strobes 0.
- Reset mid-burst aborts the burst immediately, with no ack.
- States: IDLE, F_REQ, F_WAIT, WB_READ, WB_SEND, ACK.
- IDLE:
  - CacheBusRW[0] -> WB_READ.
  - else CacheBusRW[1] -> F_REQ.
  - CacheBusRW=11 is illegal; writeback takes priority.
  - BeatCount cleared on entry to any burst.
- F_REQ:
  - MemReq=1, MemWrite=0.
  - On MemReady -> F_WAIT.
  - A same-cycle MemRValid is ignored; data is taken only in F_WAIT.
- F_WAIT:
  - On MemRValid, FetchBuffer[BEATLEN*BeatCount +: BEATLEN] <= MemRData.
  - If last beat -> ACK, else BeatCount+1 and -> F_REQ.
- WB_READ:
  - One cycle waiting for the synchronous cache read.
  - MemWData <= CacheReadDataWord; -> WB_SEND.
- WB_SEND:
  - MemReq=1, MemWrite=1, MemWData held stable.
  - On MemReady: if last beat -> ACK, else BeatCount+1 and -> WB_READ.
- ACK:
  - CacheBusAck=1 for exactly one cycle; -> IDLE.
  - FetchBuffer retains its value until the next fetch overwrites beats.
- Back-to-back: writeback followed by fetch (cache changes CacheBusRW after ack) starts from IDLE the cycle after ACK.
- Beat 0 is first; BeatCount does not wrap within a burst. The last beat is BeatCount == 2^LOGBWPL-1.
- MemReq and MemAdr stay stable while MemReady is low.
- Minimum latency per line: fetch 2N+1 cycles, writeback 2N+1 cycles, for N beats with zero-wait memory.
- CacheBusAdr and CacheBusRW are sampled every cycle and must stay stable until ack; the block does not latch them.

Decomposition:
- Shared package (cvw): state enum typedef, BEATLEN/LOGBWPL derivation constants.
- One natural sub-module: cachelinebus_fetchbuf, the beat-indexed write-enabled line register with async reset.
- FSM, counter and address generation stay in the top module.

Test Plan:
- Fetch, zero-wait memory: CacheBusRW=10, Adr=0x8000_0040, RData=beat index+0x11 -> MemAdr 0x40,0x48,0x50,0x58; FetchBuffer={0x14,0x13,0x12,0x11}; ack at cycle 9.
- Writeback with MemReady low 3 cycles on beat 1: CacheReadDataWord=0xA0+BeatCount -> MemWData sequence 0xA0..0xA3; MemReq/MemAdr/MemWData stable during the wait; single ack.
- Writeback then fetch: RW=01, then 10 the cycle after ack -> two acks; BeatCount restarts at 0 for the fetch.
- Reset asserted in F_WAIT after beat 2 -> immediately IDLE, FetchBuffer=0, no CacheBusAck, MemReq=0.
- CacheBusRW=11 in IDLE -> writeback performed (MemWrite=1 on all beats).
- Delayed MemRValid (5 cycles after accept) -> no further MemReq issued until data arrives; one outstanding transaction at a time.
